piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in/serial-out transmitter: captures a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on a framed serial line. It is the sending end of the team's flip-flop-based serial link and pairs with the serial-in/parallel-out receiver on the other end of `sout`/`sframe`. The block is built as a shift register plus a bit counter and a two-state controller.

## Interface
- `WIDTH`, default 8: word length in bits. Legal range is 2..32.
- `MSB_FIRST`, default 1: 1 shifts `din[WIDTH-1]` first; 0 shifts `din[0]` first.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  a word is present on `din`.
- `load_ready`  out  1  the block can accept a word this cycle.
- `din`  in  WIDTH  parallel word; sampled only on the accept edge.
- `sout`  out  1  serial data bit, registered.
- `sframe`  out  1  high while `sout` carries a valid data bit, registered.
- `done`  out  1  one-cycle pulse after the last bit of each frame, registered.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress.
- Reset (`rst_n` low):
  - Takes effect immediately and asynchronously.
  - Forces state = IDLE, shift register = 0, counter = 0.
  - Outputs: `sout`=0, `sframe`=0, `done`=0.
  - No edge is processed while `rst_n` is low. `load_valid` is ignored.
- `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when counter == 0 (last-bit cycle).
  - 0 otherwise.
- Accept means `load_valid` && `load_ready` at a rising edge. On accept:
  - `din` is loaded into the shift register and counter = WIDTH-1.
  - State becomes SHIFT.
  - The first bit appears on `sout` with `sframe`=1 in the next cycle.
- Each SHIFT edge without accept:
  - Shift by one position toward the output end.
  - Counter decrements. `sout` takes the next bit.
- End of frame (SHIFT edge with counter == 0):
  - Without accept: state goes to IDLE, `sframe` goes to 0, `sout` goes to 0.
  - With accept (back-to-back): the new word loads and state stays SHIFT. `sframe` stays 1 with no gap.
  - In both cases `done` = 1 for exactly the following cycle.
- Changes on `din` outside the accept edge have no effect.
- `load_valid` held high across a frame is accepted once per frame, only while `load_ready`=1.
- Counter width is clog2(WIDTH). Counter decrements never wrap because SHIFT exits at 0.

## Timing
- Accept at edge k:
  - Bit i (i = 0..WIDTH-1, in shift order) is on `sout` with `sframe`=1 during cycle k+1+i.
  - `done`=1 during cycle k+WIDTH+1.
- Throughput: one word per WIDTH cycles with back-to-back loads. Idle `sframe`=0 cycles are needed only when `load_valid` is low in the last-bit cycle.
- Latency from accept edge to first bit: 1 cycle.
- Reset mid-frame:
  - `sframe` and `sout` drop to 0 asynchronously. `done` is not pulsed for the aborted frame.
  - First accept is possible at the first rising edge after `rst_n` rises.
- `sout` is 0 whenever `sframe`=0.

## Test plan
- WIDTH=8, MSB_FIRST=1, `din`=8'hA5 accepted at edge k -> `sout` = 1,0,1,0,0,1,0,1 in cycles k+1..k+8 with `sframe`=1 throughout; `done`=1 only in cycle k+9; `load_ready`=0 in cycles k+1..k+7.
- MSB_FIRST=0, `din`=8'h01 -> `sout` = 1,0,0,0,0,0,0,0.
- Back-to-back: 8'hA5 then 8'h3C with `load_valid` held high -> 16 consecutive `sframe`=1 cycles; `sout` = 10100101 00111100; `done` pulses in cycles k+9 and k+17.
- `din` toggled every cycle during a frame of 8'hF0 -> output remains 11110000.
- `rst_n` pulled low after 3 bits of 8'hFF -> `sframe`=0, `sout`=0, and `done`=0 immediately; `load_ready`=1. A later accept of 8'h81 transmits cleanly: 1,0,0,0,0,0,0,1.
- `load_valid` low for the whole test -> `sframe`=0, `sout`=0, `done`=0, `load_ready`=1 every cycle.

Source files
------------

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx
// Purpose  : Parallel-in/serial-out transmitter with a valid/ready load
//            handshake and a framed, fully registered serial output.
// Revision : 1.0
// ============================================================================
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sframe,
    output logic             done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             sout_q,  sout_d;
    logic             sframe_q, sframe_d;
    logic             done_q,  done_d;

    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] shreg_adv;

    // The first bit goes straight to the output flop, so the shift register
    // only ever holds the bits still waiting to be sent.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign first_bit = din[WIDTH-1];
            assign din_rest  = {din[WIDTH-2:0], 1'b0};
            assign next_bit  = shreg_q[WIDTH-1];
            assign shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign first_bit = din[0];
            assign din_rest  = {1'b0, din[WIDTH-1:1]};
            assign next_bit  = shreg_q[0];
            assign shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit   = (cnt_q == '0);
    assign load_ready = (state_q == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sout_d   = sout_q;
        sframe_d = sframe_q;
        done_d   = 1'b0;

        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = din_rest;
            cnt_d    = CNT_LOAD;
            sout_d   = first_bit;
            sframe_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d  = IDLE;
                shreg_d  = '0;
                sout_d   = 1'b0;
                sframe_d = 1'b0;
            end else begin
                shreg_d  = shreg_adv;
                cnt_d    = cnt_q - CNT_ONE;
                sout_d   = next_bit;
            end
        end

        // A frame completes whether or not the next word follows back-to-back.
        if ((state_q == SHIFT) && last_bit) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sout_q   <= 1'b0;
            sframe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sout_q   <= sout_d;
            sframe_q <= sframe_d;
            done_q   <= done_d;
        end
    end

    assign sout   = sout_q;
    assign sframe = sframe_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx
// Purpose  : Self-checking bench for piso_tx (MSB-first and LSB-first copies).
// Revision : 1.0
// ============================================================================
module tb_piso_tx;

    logic       clk;
    logic       rst_n;
    logic       lv_m, lv_l;
    logic [7:0] din_m, din_l;
    logic       rdy_m, rdy_l;
    logic       sout_m, sout_l;
    logic       sfr_m, sfr_l;
    logic       done_m, done_l;

    int n_cmp;
    int n_err;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (lv_m),
        .load_ready (rdy_m),
        .din        (din_m),
        .sout       (sout_m),
        .sframe     (sfr_m),
        .done       (done_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (lv_l),
        .load_ready (rdy_l),
        .din        (din_l),
        .sout       (sout_l),
        .sframe     (sfr_l),
        .done       (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       lv;
        logic [7:0] din;
        logic       sout;
        logic       sframe;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_m(input string tag, input logic s, input logic f,
                           input logic d, input logic r);
        check({tag, ".sout"},   sout_m, s);
        check({tag, ".sframe"}, sfr_m,  f);
        check({tag, ".done"},   done_m, d);
        check({tag, ".ready"},  rdy_m,  r);
    endtask

    // Expects a frame starting in the current cycle; bits given in shift order
    // (bit 7 of exp is sent first). din is toggled every cycle meanwhile.
    task automatic expect_frame(input string tag, input bit use_lsb, input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            if (use_lsb) begin
                check({tag, ".sout"},   sout_l, exp[7-i]);
                check({tag, ".sframe"}, sfr_l,  1'b1);
                check({tag, ".ready"},  rdy_l,  i == 7);
                din_l = ~din_l;
            end else begin
                check({tag, ".sout"},   sout_m, exp[7-i]);
                check({tag, ".sframe"}, sfr_m,  1'b1);
                check({tag, ".ready"},  rdy_m,  i == 7);
                din_m = ~din_m;
            end
            @(negedge clk);
        end
        if (use_lsb) begin
            check({tag, ".end_sframe"}, sfr_l,  1'b0);
            check({tag, ".end_sout"},   sout_l, 1'b0);
            check({tag, ".end_done"},   done_l, 1'b1);
        end else begin
            check({tag, ".end_sframe"}, sfr_m,  1'b0);
            check({tag, ".end_sout"},   sout_m, 1'b0);
            check({tag, ".end_done"},   done_m, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        lv_m  = 1'b0;
        lv_l  = 1'b0;
        din_m = 8'h00;
        din_l = 8'h00;

        // Back-to-back A5 then 3C, load_valid held high through the first frame.
        pa = 8'hA5;
        pb = 8'h3C;
        vecs[0] = '{lv: 1'b1, din: 8'hA5, sout: 1'b0, sframe: 1'b0, done: 1'b0, ready: 1'b1};
        for (int c = 1; c <= 8; c++)
            vecs[c] = '{lv: 1'b1, din: 8'h3C, sout: pa[8-c], sframe: 1'b1,
                        done: 1'b0, ready: (c == 8)};
        for (int c = 9; c <= 16; c++)
            vecs[c] = '{lv: 1'b0, din: 8'h00, sout: pb[16-c], sframe: 1'b1,
                        done: (c == 9), ready: (c == 16)};
        vecs[17] = '{lv: 1'b0, din: 8'h00, sout: 1'b0, sframe: 1'b0, done: 1'b1, ready: 1'b1};
        vecs[18] = '{lv: 1'b0, din: 8'h00, sout: 1'b0, sframe: 1'b0, done: 1'b0, ready: 1'b1};

        // Reset state, with load_valid asserted to show it is ignored.
        repeat (2) @(negedge clk);
        lv_m = 1'b1;
        din_m = 8'hFF;
        @(negedge clk);
        check_m("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset.lsb_sframe", sfr_l, 1'b0);
        lv_m  = 1'b0;
        rst_n = 1'b1;

        // Idle with load_valid low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_m("idle", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Table-driven back-to-back frames.
        for (int c = 0; c < 19; c++) begin
            check_m($sformatf("vec%0d", c), vecs[c].sout, vecs[c].sframe,
                    vecs[c].done, vecs[c].ready);
            lv_m  = vecs[c].lv;
            din_m = vecs[c].din;
            @(negedge clk);
        end

        // F0 with din toggling every cycle during the frame.
        lv_m  = 1'b1;
        din_m = 8'hF0;
        @(negedge clk);
        lv_m = 1'b0;
        expect_frame("f0", 1'b0, 8'hF0);
        @(negedge clk);

        // Reset after three bits of FF, then a clean 81 frame.
        lv_m  = 1'b1;
        din_m = 8'hFF;
        @(negedge clk);
        lv_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ff.sout", sout_m, 1'b1);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check_m("abort", 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_m("abort_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        lv_m  = 1'b1;
        din_m = 8'h81;
        @(negedge clk);
        lv_m = 1'b0;
        expect_frame("x81", 1'b0, 8'h81);
        @(negedge clk);
        check("x81.done_once", done_m, 1'b0);

        // LSB-first copy: 01 goes out as 1 followed by seven zeros.
        lv_l  = 1'b1;
        din_l = 8'h01;
        @(negedge clk);
        lv_l = 1'b0;
        expect_frame("lsb01", 1'b1, 8'h80);
        @(negedge clk);
        check("lsb01.done_once", done_l, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
